// File: rtl/vm_defs.sv
// vm_defs: money width, coin values and dispenser state encoding shared across the vending machine
package vm_defs;
    localparam int MONEY_W = 12;
    localparam int V_5Y    = 50;
    localparam int V_1Y    = 10;
    localparam int V_5J    = 5;
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_PULSE, S_GAP, S_DONE} state_t;
endpackage

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter whose expire strobe marks the last cycle of a timed interval
module pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expire
);
    logic [W-1:0] r_cnt;
    // reload on request, otherwise count down and rest at zero
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_cnt <= '0;
        else if (i_load) r_cnt <= i_value;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    // a zero-length load still yields a single-cycle interval instead of hanging
    assign o_expire = r_cnt <= W'(1);
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out remaining credit greedily as 5-yuan, 1-yuan and 5-jiao coin pulses
module change_dispenser
    import vm_defs::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MONEY_W-1:0] amount,
    input  logic               abort,
    input  logic               empty_5y,
    input  logic               empty_1y,
    input  logic               empty_5j,
    output logic               busy,
    output logic               coin_5y,
    output logic               coin_1y,
    output logic               coin_5j,
    output logic               done,
    output logic [MONEY_W-1:0] residue,
    output logic [5:0]         n_5y,
    output logic [5:0]         n_1y,
    output logic [5:0]         n_5j
);
    localparam int T_MAX = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
    localparam int T_W   = $clog2(T_MAX + 1);
    state_t             r_state;
    logic [MONEY_W-1:0] r_remain;
    logic               r_abort;
    logic               w_ok_5y, w_ok_1y, w_ok_5j, w_go, w_load, w_expire;
    logic [MONEY_W-1:0] w_paid;
    logic [T_W-1:0]     w_value;
    assign w_ok_5y = !empty_5y && r_remain >= MONEY_W'(V_5Y);
    assign w_ok_1y = !empty_1y && r_remain >= MONEY_W'(V_1Y);
    assign w_ok_5j = !empty_5j && r_remain >= MONEY_W'(V_5J);
    assign w_go    = !r_abort && (w_ok_5y || w_ok_1y || w_ok_5j);
    assign w_paid  = coin_5y ? MONEY_W'(V_5Y) : coin_1y ? MONEY_W'(V_1Y) : MONEY_W'(V_5J);
    assign w_load  = (r_state == S_SEL && w_go) || (r_state == S_PULSE && w_expire);
    assign w_value = r_state == S_SEL ? T_W'(PULSE_CYCLES) : T_W'(GAP_CYCLES);
    pulse_timer #(.W(T_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_value  (w_value),
        .o_expire (w_expire)
    );
    // payout sequencer; the active coin output doubles as the record of which coin is in flight
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state  <= S_IDLE;
            r_remain <= '0;
            r_abort  <= 1'b0;
            busy     <= 1'b0;
            coin_5y  <= 1'b0;
            coin_1y  <= 1'b0;
            coin_5j  <= 1'b0;
            done     <= 1'b0;
            residue  <= '0;
            n_5y     <= '0;
            n_1y     <= '0;
            n_5j     <= '0;
        end else begin
            if (r_state != S_IDLE && abort) r_abort <= 1'b1;
            case (r_state)
                S_IDLE: if (start) begin
                    r_remain <= amount;
                    residue  <= '0;
                    n_5y     <= '0;
                    n_1y     <= '0;
                    n_5j     <= '0;
                    busy     <= 1'b1;
                    r_state  <= S_SEL;
                end
                S_SEL: if (w_go) begin
                    coin_5y <= w_ok_5y;
                    coin_1y <= !w_ok_5y && w_ok_1y;
                    coin_5j <= !w_ok_5y && !w_ok_1y && w_ok_5j;
                    r_state <= S_PULSE;
                end else begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    residue <= r_remain;
                    r_state <= S_DONE;
                end
                S_PULSE: if (w_expire) begin
                    r_remain <= r_remain - w_paid;
                    n_5y     <= n_5y + 6'(coin_5y && n_5y != 6'd63);
                    n_1y     <= n_1y + 6'(coin_1y && n_1y != 6'd63);
                    n_5j     <= n_5j + 6'(coin_5j && n_5j != 6'd63);
                    coin_5y  <= 1'b0;
                    coin_1y  <= 1'b0;
                    coin_5j  <= 1'b0;
                    r_state  <= S_GAP;
                end
                S_GAP: if (w_expire) r_state <= S_SEL;
                S_DONE: begin
                    done    <= 1'b0;
                    r_abort <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and random payouts checked against a greedy-payout timeline model
module tb_change_dispenser;
    localparam int P    = 4;
    localparam int G    = 2;
    localparam int STEP = 1 + P + G;

    logic        clk = 0, reset = 0, start = 0, abort = 0;
    logic        empty_5y = 0, empty_1y = 0, empty_5j = 0;
    logic [11:0] amount = 0;
    logic        busy, coin_5y, coin_1y, coin_5j, done;
    logic [11:0] residue;
    logic [5:0]  n_5y, n_1y, n_5j;

    int compared = 0, mismatched = 0;
    int dn;
    logic [2:0] exp_coin [0:2047];

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount), .abort(abort),
        .empty_5y(empty_5y), .empty_1y(empty_1y), .empty_5j(empty_5j),
        .busy(busy), .coin_5y(coin_5y), .coin_1y(coin_1y), .coin_5j(coin_5j),
        .done(done), .residue(residue), .n_5y(n_5y), .n_1y(n_1y), .n_5j(n_5j)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ab = cycle in which abort is pulsed (0 = the IDLE start cycle, <0 = never)
    task automatic run(input int amt, input bit e5y, input bit e1y, input bit e5j,
                       input int ab, output int got_done);
        int vals [3] = '{50, 10, 5};
        bit emp [3];
        int n [3];
        int remain, t, c, done_c, sat;
        emp = '{e5y, e1y, e5j};
        n = '{0, 0, 0};
        remain = amt;
        t = 1;
        for (int i = 0; i < 2048; i++) exp_coin[i] = '0;
        c = 0;
        while (c >= 0) begin
            c = -1;
            if (!(ab >= 1 && ab < t))
                for (int i = 2; i >= 0; i--) if (!emp[i] && remain >= vals[i]) c = i;
            if (c >= 0) begin
                for (int k = 1; k <= P; k++) exp_coin[t + k] = 3'b100 >> c;
                remain -= vals[c];
                n[c]++;
                t += STEP;
            end
        end
        done_c = t + 1;
        @(posedge clk); #1;
        start = 1; amount = 12'(amt); abort = (ab == 0);
        empty_5y = e5y; empty_1y = e1y; empty_5j = e5j;
        got_done = -1;
        for (int cy = 1; cy <= done_c; cy++) begin
            @(posedge clk); #1;
            start = 0; abort = (ab == cy);
            @(negedge clk);
            chk($sformatf("outs amt=%0d cyc=%0d", amt, cy), {busy, coin_5y, coin_1y, coin_5j, done},
                {cy < done_c, exp_coin[cy], cy == done_c});
            if (done && got_done < 0) got_done = cy;
        end
        chk($sformatf("residue amt=%0d", amt), residue, remain);
        sat = n[0] > 63 ? 63 : n[0];
        chk($sformatf("n_5y amt=%0d", amt), n_5y, sat);
        sat = n[1] > 63 ? 63 : n[1];
        chk($sformatf("n_1y amt=%0d", amt), n_1y, sat);
        sat = n[2] > 63 ? 63 : n[2];
        chk($sformatf("n_5j amt=%0d", amt), n_5j, sat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outs", {busy, coin_5y, coin_1y, coin_5j, done}, 0);
        chk("reset residue", residue, 0);
        chk("reset counts", {n_5y, n_1y, n_5j}, 0);
        @(posedge clk); #1 reset = 1;

        run(65, 0, 0, 0, -1, dn);
        chk("65 done cycle", dn, 23);
        chk("65 counts", {n_5y, n_1y, n_5j}, {6'd1, 6'd1, 6'd1});
        run(0, 0, 0, 0, -1, dn);
        chk("0 done cycle", dn, 2);
        run(7, 0, 0, 0, -1, dn);
        chk("7 done cycle", dn, 9);
        chk("7 residue", residue, 2);
        run(100, 1, 0, 0, -1, dn);
        chk("100 no5y done cycle", dn, 72);
        chk("100 no5y n_1y", n_1y, 10);
        run(120, 0, 0, 0, 3, dn);
        chk("120 abort done cycle", dn, 9);
        chk("120 abort residue", residue, 70);
        run(65, 0, 0, 0, 0, dn);
        chk("idle abort ignored", dn, 23);
        run(400, 1, 1, 0, -1, dn);
        chk("n_5j saturates", n_5j, 63);
        chk("400 done cycle", dn, 562);

        @(posedge clk); #1;
        start = 1; amount = 12'd50; abort = 0;
        empty_5y = 0; empty_1y = 0; empty_5j = 0;
        repeat (4) @(posedge clk);
        #1;
        start = 0;
        chk("coin before reset", coin_5y, 1);
        reset = 0;
        #1;
        chk("mid-pulse reset outs", {busy, coin_5y, coin_1y, coin_5j, done}, 0);
        chk("mid-pulse reset counts", {n_5y, n_1y, n_5j, residue}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        run(50, 0, 0, 0, -1, dn);
        chk("after reset done cycle", dn, 9);

        for (int r = 0; r < 25; r++) begin
            int amt, ab;
            bit e5y, e1y, e5j;
            amt = $urandom_range(0, 600);
            e5y = $urandom_range(0, 3) == 0;
            e1y = $urandom_range(0, 3) == 0;
            e5j = $urandom_range(0, 3) == 0;
            ab  = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 40)) : -1;
            run(amt, e5y, e1y, e5j, ab, dn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
